// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and helpers for the multiport register file
package regfile_pkg;

   localparam int DEF_WIDTH    = 16;
   localparam int DEF_DEPTH    = 32;
   localparam int DEF_NUM_RD   = 2;
   localparam int DEF_ZERO_REG = 0;

   localparam logic [DEF_WIDTH-1:0] ZERO_WORD = '0;

   // A depth of 2 still needs one address bit, so never return zero.
   function automatic int addr_bits(input int depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one registered read port with range check, zero entry and write bypass
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int ZERO_REG = DEF_ZERO_REG,
   parameter int ADDR_W   = addr_bits(DEF_DEPTH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [DEPTH*WIDTH-1:0]   mem_flat_i,
   input  logic                     rd_en_i,
   input  logic [ADDR_W-1:0]        rd_addr_i,
   input  logic                     wr_en_i,
   input  logic [ADDR_W-1:0]        wr_addr_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic                     rd_valid_o
);

   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

   logic              in_range;
   logic              zero_hit;
   logic              bypass;
   logic [WIDTH-1:0]  entry;
   logic [WIDTH-1:0]  rd_data_d, rd_data_q;
   logic              rd_valid_d, rd_valid_q;

   assign in_range = ({1'b0, rd_addr_i} < DEPTH_LIM);
   assign zero_hit = (ZERO_REG != 0) && (rd_addr_i == '0);
   // Matching addresses means the write is in range too; zero_hit excludes the read-only entry.
   assign bypass   = wr_en_i && in_range && !zero_hit && (wr_addr_i == rd_addr_i);

   // Loop mux keeps non-power-of-two depths from indexing past the array.
   always_comb begin
      entry = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (rd_addr_i == ADDR_W'(i)) begin
            entry = mem_flat_i[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_en_i;
      if (rd_en_i) begin
         if (!in_range || zero_hit) begin
            rd_data_d = '0;
         end else if (bypass) begin
            rd_data_d = wr_data_i;
         end else begin
            rd_data_d = entry;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_data_o  = rd_data_q;
   assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - parametrised register file, one write port and NUM_RD registered read ports
module regfile_multiport
   import regfile_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int ZERO_REG = DEF_ZERO_REG,
   localparam int ADDR_W  = addr_bits(DEPTH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [NUM_RD-1:0]        rd_en,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*WIDTH-1:0]  rd_data,
   output logic [NUM_RD-1:0]        rd_valid
);

   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

   logic [WIDTH-1:0]       mem_d [DEPTH];
   logic [WIDTH-1:0]       mem_q [DEPTH];
   logic [DEPTH*WIDTH-1:0] mem_flat;
   logic                   wr_ok;

   assign wr_ok = wr_en
                  && ({1'b0, wr_addr} < DEPTH_LIM)
                  && !((ZERO_REG != 0) && (wr_addr == '0));

   always_comb begin
      mem_d = mem_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_ok && (wr_addr == ADDR_W'(i))) begin
            mem_d[i] = wr_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   always_comb begin
      mem_flat = '0;
      for (int i = 0; i < DEPTH; i++) begin
         mem_flat[i*WIDTH +: WIDTH] = mem_q[i];
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      regfile_read_port #(
         .WIDTH    (WIDTH),
         .DEPTH    (DEPTH),
         .ZERO_REG (ZERO_REG),
         .ADDR_W   (ADDR_W)
      ) u_port (
         .clk        (clk),
         .reset      (reset),
         .mem_flat_i (mem_flat),
         .rd_en_i    (rd_en[p]),
         .rd_addr_i  (rd_addr[p*ADDR_W +: ADDR_W]),
         .wr_en_i    (wr_en),
         .wr_addr_i  (wr_addr),
         .wr_data_i  (wr_data),
         .rd_data_o  (rd_data[p*WIDTH +: WIDTH]),
         .rd_valid_o (rd_valid[p])
      );
   end

endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - randomized and directed bench for two register file configurations
module tb_regfile_multiport;

   logic        clk;
   logic        reset;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [15:0] wr_data;
   logic [1:0]  rd_en;
   logic [9:0]  rd_addr;
   logic [31:0] rd_data_a, rd_data_b;
   logic [1:0]  rd_valid_a, rd_valid_b;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference state: an array per configuration; reads return the post-write contents.
   int          dep [2] = '{32, 24};
   int          zr  [2] = '{0, 1};
   logic [15:0] mem_m [2][32];
   logic [15:0] exp_d [2][2];
   logic        exp_v [2][2];

   regfile_multiport #(.WIDTH(16), .DEPTH(32), .NUM_RD(2), .ZERO_REG(0)) u_dut_a (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a)
   );

   regfile_multiport #(.WIDTH(16), .DEPTH(24), .NUM_RD(2), .ZERO_REG(1)) u_dut_b (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [15:0] port_data(input int d, input int p);
      return (d == 0) ? rd_data_a[p*16 +: 16] : rd_data_b[p*16 +: 16];
   endfunction

   function automatic logic port_valid(input int d, input int p);
      return (d == 0) ? rd_valid_a[p] : rd_valid_b[p];
   endfunction

   task automatic idle();
      reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = '0; rd_addr = '0;
   endtask

   task automatic cycle();
      int a;
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            for (int i = 0; i < 32; i++) mem_m[d][i] = '0;
            for (int p = 0; p < 2; p++) begin exp_d[d][p] = '0; exp_v[d][p] = 1'b0; end
         end else begin
            if (wr_en && int'(wr_addr) < dep[d] && !(zr[d] != 0 && wr_addr == 0))
               mem_m[d][wr_addr] = wr_data;
            for (int p = 0; p < 2; p++) begin
               exp_v[d][p] = rd_en[p];
               if (rd_en[p]) begin
                  a = int'(rd_addr[p*5 +: 5]);
                  exp_d[d][p] = (a < dep[d]) ? mem_m[d][a] : 16'h0000;
               end
            end
         end
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         for (int p = 0; p < 2; p++) begin
            check($sformatf("dut%0d.p%0d.data", d, p), 32'(port_data(d, p)), 32'(exp_d[d][p]));
            check($sformatf("dut%0d.p%0d.valid", d, p), 32'(port_valid(d, p)), 32'(exp_v[d][p]));
         end
      end
   endtask

   task automatic read2(input int a0, input int a1);
      rd_en = 2'b11; rd_addr = {5'(a1), 5'(a0)};
      cycle();
   endtask

   initial begin
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 32; i++) mem_m[d][i] = '0;
      idle();
      reset = 1'b1;
      cycle();
      check("reset_valid_a", 32'(rd_valid_a), 32'h0);
      check("reset_data_b", rd_data_b, 32'h0);
      idle();

      // Reads straight after reset return zero with valid one cycle later
      foreach (dep[k]) begin end
      rd_en = 2'b01; rd_addr = 10'd0;  cycle(); check("post_reset_rd0", 32'(rd_data_a[15:0]), 32'h0);
      rd_addr = 10'd5;  cycle(); check("post_reset_rd5_valid", 32'(rd_valid_a[0]), 32'h1);
      rd_addr = 10'd31; cycle(); check("post_reset_rd31", 32'(rd_data_a[15:0]), 32'h0);
      idle();

      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 16'hBEEF; cycle(); idle();
      read2(7, 7);
      check("beef_both_ports", rd_data_a, 32'hBEEF_BEEF);
      idle();
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("hold_beef", 32'(rd_data_a[15:0]), 32'hBEEF);
         check("hold_valid_low", 32'(rd_valid_a), 32'h0);
      end

      // Bypass: same-cycle write and read of entry 3
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 16'h1111; cycle();
      wr_data = 16'h2222; rd_en = 2'b10; rd_addr = {5'd3, 5'd0}; cycle();
      check("bypass_new_value", 32'(rd_data_a[31:16]), 32'h2222);
      idle(); read2(3, 3);
      check("after_bypass", 32'(rd_data_b[31:16]), 32'h2222);

      // Entry 0 is hardwired only in the second configuration
      idle(); wr_en = 1'b1; wr_addr = 5'd0; wr_data = 16'hFFFF; rd_en = 2'b01; rd_addr = 10'd0; cycle();
      check("zero_reg_same_cycle", 32'(rd_data_b[15:0]), 32'h0);
      idle(); read2(0, 0);
      check("zero_reg_next_cycle", 32'(rd_data_b[15:0]), 32'h0);

      // Write beyond DEPTH=24 is dropped in the second configuration
      idle(); wr_en = 1'b1; wr_addr = 5'd30; wr_data = 16'hABCD; cycle();
      idle(); read2(30, 23);
      check("out_of_range_rd", 32'(rd_data_b[15:0]), 32'h0);
      for (int i = 0; i < 32; i += 2) read2(i, i + 1);

      // Fill, then reset while a write is pending
      idle();
      for (int i = 0; i < 32; i++) begin
         wr_en = 1'b1; wr_addr = 5'(i); wr_data = 16'h0100 + 16'(i); cycle();
      end
      idle(); read2(4, 31);
      check("filled_entry4", 32'(rd_data_a[15:0]), 32'h0104);
      reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 16'h5555; rd_en = 2'b11; cycle();
      idle();
      for (int i = 0; i < 32; i += 2) read2(i, i + 1);
      idle(); read2(4, 4);
      check("reset_dropped_write", 32'(rd_data_a[15:0]), 32'h0);

      // Random traffic, biased towards write/read address collisions
      for (int n = 0; n < 600; n++) begin
         reset   = ($urandom_range(0, 63) == 0);
         wr_en   = $urandom_range(0, 1);
         wr_addr = 5'($urandom_range(0, 31));
         wr_data = 16'($urandom);
         rd_en   = 2'($urandom_range(0, 3));
         for (int p = 0; p < 2; p++)
            rd_addr[p*5 +: 5] = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom_range(0, 31));
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
